// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the execution controller and the serial debug unit:
// command opcodes, controller states, halt causes and the core's reset PC.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_STEP    = 3'd2,
    OP_HALT    = 3'd3,
    OP_SET_BP  = 3'd4,
    OP_CLR_BP  = 3'd5,
    OP_CLR_CNT = 3'd6,
    OP_RSVD    = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } exec_state_e;

  typedef enum logic [1:0] {
    CAUSE_RESET      = 2'd0,
    CAUSE_HALT_CMD   = 2'd1,
    CAUSE_STEP_DONE  = 2'd2,
    CAUSE_BREAKPOINT = 2'd3
  } halt_cause_e;

  // Breakpoints compare word addresses only (PC[31:2]).
  localparam int WADDR_W = 30;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/bp_match_bank.sv
// PC breakpoint slots: word address plus enable per slot, compared in parallel
// against the core's next PC; the lowest matching slot wins.
module bp_match_bank
  import cpu_dbg_pkg::*;
#(
  parameter int NBP = 4,
  localparam int IDX_W = (NBP > 1) ? $clog2(NBP) : 1
) (
  input  logic               clk_cpu,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic               clr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [WADDR_W-1:0] wr_addr,
  input  logic [WADDR_W-1:0] chk_addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [WADDR_W-1:0] addr_q [NBP];
  logic [WADDR_W-1:0] addr_d [NBP];
  logic [NBP-1:0]     en_q;
  logic [NBP-1:0]     en_d;
  logic [NBP-1:0]     match;

  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    for (int i = 0; i < NBP; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        if (wr_en) begin
          addr_d[i] = wr_addr;
          en_d[i]   = 1'b1;
        end else if (clr_en) begin
          en_d[i] = 1'b0;
        end
      end
    end
  end

  // Addresses are only meaningful while enabled, so they carry no reset.
  always_ff @(posedge clk_cpu) begin
    addr_q <= addr_d;
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      en_q <= '0;
    end else begin
      en_q <= en_d;
    end
  end

  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = 0; i < NBP; i++) begin
      match[i] = en_q[i] && (addr_q[i] == chk_addr);
    end
    hit = |match;
    // Walk downwards so the lowest matching slot is the last one written.
    for (int i = NBP - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution controller: owns the core's commit enable and the debug-port select,
// sequencing halt / run / N-step / breakpoint stop with a one-cycle drain.
module cpu_exec_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int NBP   = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = (NBP > 1) ? $clog2(NBP) : 1
) (
  input  logic             clk_cpu,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [31:0]      cmd_data,
  output logic             cmd_err,
  input  logic [31:0]      npc,
  output logic             cpu_en,
  output logic             debug,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [IDX_W-1:0] bp_idx,
  output logic [31:0]      instr_cnt
);

  exec_state_e      state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bp_idx_q, bp_idx_d;
  logic [31:0]      instr_cnt_q, instr_cnt_d;
  logic             cpu_en_q, cpu_en_d;
  logic             debug_q, debug_d;
  logic             halted_q, halted_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_err_q, cmd_err_d;

  cmd_op_e          op;
  logic             accept;
  logic [CNT_W-1:0] step_n;
  logic             bp_wr;
  logic             bp_clr;
  logic             cnt_clr;
  logic             bp_hit;
  logic [IDX_W-1:0] hit_idx;
  logic             unused_npc_lsb;

  assign op             = cmd_op_e'(cmd_op);
  assign accept         = cmd_valid & cmd_ready_q;
  assign step_n         = (cmd_data[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_data[CNT_W-1:0];
  assign unused_npc_lsb = ^npc[1:0];

  bp_match_bank #(
    .NBP (NBP)
  ) u_bp_bank (
    .clk_cpu  (clk_cpu),
    .rstn     (rstn),
    .wr_en    (bp_wr),
    .clr_en   (bp_clr),
    .wr_idx   (cmd_idx),
    .wr_addr  (cmd_data[31:2]),
    .chk_addr (npc[31:2]),
    .hit      (bp_hit),
    .idx      (hit_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    bp_idx_d  = bp_idx_q;
    cmd_err_d = 1'b0;
    bp_wr     = 1'b0;
    bp_clr    = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (accept) begin
          case (op)
            OP_RUN:     state_d = ST_RUN;
            OP_STEP: begin
              cnt_d   = step_n;
              state_d = ST_STEP;
            end
            OP_SET_BP:  bp_wr     = 1'b1;
            OP_CLR_BP:  bp_clr    = 1'b1;
            OP_CLR_CNT: cnt_clr   = 1'b1;
            OP_RSVD:    cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (accept) begin
          case (op)
            OP_HALT: begin
              state_d = ST_DRAIN;
              cause_d = CAUSE_HALT_CMD;
            end
            OP_SET_BP:  bp_wr   = 1'b1;
            OP_CLR_BP:  bp_clr  = 1'b1;
            OP_CLR_CNT: cnt_clr = 1'b1;
            OP_RUN, OP_STEP, OP_RSVD: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_DRAIN;
          cause_d = CAUSE_STEP_DONE;
        end
      end
      ST_DRAIN: state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase

    // A breakpoint on the next PC outranks both a HALT command and step completion.
    if (bp_hit && (state_q == ST_RUN || state_q == ST_STEP)) begin
      state_d  = ST_DRAIN;
      cause_d  = CAUSE_BREAKPOINT;
      bp_idx_d = hit_idx;
    end

    cpu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    debug_d     = (state_d == ST_HALT);
    halted_d    = (state_d == ST_HALT);
    cmd_ready_d = (state_d == ST_HALT) || (state_d == ST_RUN);

    if (cnt_clr) begin
      instr_cnt_d = '0;
    end else if (cpu_en_q) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HALT;
      cnt_q       <= '0;
      cause_q     <= CAUSE_RESET;
      bp_idx_q    <= '0;
      instr_cnt_q <= '0;
      cpu_en_q    <= 1'b0;
      debug_q     <= 1'b1;
      halted_q    <= 1'b1;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      bp_idx_q    <= bp_idx_d;
      instr_cnt_q <= instr_cnt_d;
      cpu_en_q    <= cpu_en_d;
      debug_q     <= debug_d;
      halted_q    <= halted_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign debug      = debug_q;
  assign halted     = halted_q;
  assign cmd_ready  = cmd_ready_q;
  assign cmd_err    = cmd_err_q;
  assign halt_cause = cause_q;
  assign bp_idx     = bp_idx_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Bench for cpu_exec_ctrl: a tiny sequential-PC core plus a transaction-level
// prediction of how many instructions each RUN/STEP retires and why it stops.
module tb_cpu_exec_ctrl;
  import cpu_dbg_pkg::*;

  localparam int NBP   = 4;
  localparam int CNT_W = 16;
  localparam int IDX_W = 2;

  logic             clk_cpu = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [IDX_W-1:0] cmd_idx = '0;
  logic [31:0]      cmd_data = '0;
  logic             cmd_err;
  logic [31:0]      npc;
  logic             cpu_en;
  logic             debug;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [IDX_W-1:0] bp_idx;
  logic [31:0]      instr_cnt;

  cpu_exec_ctrl #(.NBP(NBP), .CNT_W(CNT_W)) dut (
    .clk_cpu    (clk_cpu),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .cmd_data   (cmd_data),
    .cmd_err    (cmd_err),
    .npc        (npc),
    .cpu_en     (cpu_en),
    .debug      (debug),
    .halted     (halted),
    .halt_cause (halt_cause),
    .bp_idx     (bp_idx),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Straight-line core: PC advances by one word on every committed cycle.
  logic [31:0] pc;
  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = '0;
  assign npc = pc + 32'd4;
  always @(posedge clk_cpu or negedge rstn) begin
    if (!rstn)        pc <= RESET_PC;
    else if (pc_set)  pc <= pc_set_val;
    else if (cpu_en)  pc <= pc + 32'd4;
  end

  int en_total = 0;
  int drain_total = 0;
  always @(posedge clk_cpu) begin
    #1;
    if (cpu_en) en_total++;
    if (!cpu_en && !debug) drain_total++;
  end

  logic [29:0]      m_addr [NBP];
  logic             m_en   [NBP];
  logic [31:0]      m_cnt;
  logic [1:0]       m_cause;
  logic [IDX_W-1:0] m_bpidx;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_set_val = v;
    pc_set = 1'b1;
    @(negedge clk_cpu);
    pc_set = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] op, input int idx, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = IDX_W'(idx);
    cmd_data  = data;
    @(negedge clk_cpu);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    case (op)
      OP_SET_BP:  begin m_addr[idx] = data[31:2]; m_en[idx] = 1'b1; end
      OP_CLR_BP:  m_en[idx] = 1'b0;
      OP_CLR_CNT: m_cnt = '0;
      default: ;
    endcase
  endtask

  // Number of instructions from p until npc reaches an enabled breakpoint (0 = none within maxk).
  function automatic int first_hit(input logic [31:0] p, input int maxk, output int slot);
    slot = 0;
    for (int k = 1; k <= maxk; k++) begin
      for (int s = 0; s < NBP; s++) begin
        if (m_en[s] && m_addr[s] == (p[31:2] + 30'(k))) begin
          slot = s;
          return k;
        end
      end
    end
    return 0;
  endfunction

  task automatic wait_halt(input string tag);
    int i = 0;
    while (!halted && i < 500) begin
      @(negedge clk_cpu);
      i++;
    end
    check({tag, " halt reached"}, 32'(halted), 32'd1);
  endtask

  task automatic exec_and_check(input string tag, input logic [2:0] op, input int n);
    int k, slot, en0, dr0, exp_en, nn;
    logic [1:0] exp_cause;
    if (op == OP_STEP) begin
      nn = (n == 0) ? 1 : n;
      k = first_hit(pc, nn, slot);
      if (k != 0) begin exp_en = k; exp_cause = 2'd3; end
      else begin exp_en = nn; exp_cause = 2'd2; end
    end else begin
      k = first_hit(pc, 256, slot);
      exp_en = k;
      exp_cause = 2'd3;
    end
    if (exp_cause == 2'd3) m_bpidx = IDX_W'(slot);
    m_cause = exp_cause;
    m_cnt = m_cnt + 32'(exp_en);
    en0 = en_total;
    dr0 = drain_total;
    send(op, 0, 32'(n));
    check({tag, " cmd_err"}, 32'(cmd_err), 32'd0);
    wait_halt(tag);
    check({tag, " commit cycles"}, 32'(en_total - en0), 32'(exp_en));
    check({tag, " drain cycles"}, 32'(drain_total - dr0), 32'd1);
    check({tag, " halt_cause"}, 32'(halt_cause), 32'(m_cause));
    check({tag, " bp_idx"}, 32'(bp_idx), 32'(m_bpidx));
    check({tag, " instr_cnt"}, instr_cnt, m_cnt);
    check({tag, " debug"}, 32'(debug), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cpu_en"}, 32'(cpu_en), 32'd0);
    check({tag, " debug"}, 32'(debug), 32'd1);
    check({tag, " halted"}, 32'(halted), 32'd1);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " cmd_err"}, 32'(cmd_err), 32'd0);
    check({tag, " halt_cause"}, 32'(halt_cause), 32'd0);
    check({tag, " bp_idx"}, 32'(bp_idx), 32'd0);
    check({tag, " instr_cnt"}, instr_cnt, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, dr0, act, s, k, slot, n;
    for (int i = 0; i < NBP; i++) begin m_en[i] = 1'b0; m_addr[i] = '0; end
    m_cnt = '0; m_cause = 2'd0; m_bpidx = '0;

    repeat (3) @(negedge clk_cpu);
    rstn = 1'b1;
    repeat (10) @(negedge clk_cpu);
    check_reset_values("idle");

    exec_and_check("step3", OP_STEP, 3);
    check("step3 abs count", instr_cnt, 32'd3);
    exec_and_check("step0", OP_STEP, 0);
    check("step0 abs count", instr_cnt, 32'd4);

    send(OP_SET_BP, 1, 32'h0000_3010);
    set_pc(RESET_PC);
    exec_and_check("run bp1", OP_RUN, 0);
    check("run bp1 pc", pc, 32'h0000_3010);
    send(OP_SET_BP, 3, 32'h0000_3022);
    exec_and_check("rerun past bp", OP_RUN, 0);
    check("rerun past bp pc", pc, 32'h0000_3020);

    send(OP_CLR_BP, 1, 32'd0);
    send(OP_CLR_BP, 3, 32'd0);
    send(OP_SET_BP, 0, 32'h0000_3008);
    send(OP_SET_BP, 2, 32'h0000_3008);
    set_pc(RESET_PC);
    exec_and_check("dual bp low", OP_RUN, 0);
    send(OP_CLR_BP, 0, 32'd0);
    set_pc(RESET_PC);
    exec_and_check("dual bp after clr", OP_RUN, 0);

    // HALT accepted on the very edge where npc hits slot 2.
    set_pc(RESET_PC);
    en0 = en_total; dr0 = drain_total;
    send(OP_RUN, 0, 32'd0);
    @(negedge clk_cpu);
    send(OP_HALT, 0, 32'd0);
    wait_halt("halt+bp");
    m_cnt = m_cnt + 32'd2; m_cause = 2'd3; m_bpidx = 2'd2;
    check("halt+bp cause", 32'(halt_cause), 32'd3);
    check("halt+bp drain", 32'(drain_total - dr0), 32'd1);
    check("halt+bp commits", 32'(en_total - en0), 32'd2);
    check("halt+bp bp_idx", 32'(bp_idx), 32'd2);
    check("halt+bp instr_cnt", instr_cnt, m_cnt);

    send(OP_CLR_BP, 2, 32'd0);
    en0 = en_total; dr0 = drain_total;
    send(OP_RUN, 0, 32'd0);
    send(OP_STEP, 0, 32'd5);
    check("step in run err", 32'(cmd_err), 32'd1);
    check("step in run cpu_en", 32'(cpu_en), 32'd1);
    check("step in run halted", 32'(halted), 32'd0);
    send(OP_HALT, 0, 32'd0);
    check("halt cmd err", 32'(cmd_err), 32'd0);
    wait_halt("halt cmd");
    m_cnt = m_cnt + 32'd2; m_cause = 2'd1;
    check("halt cmd cause", 32'(halt_cause), 32'd1);
    check("halt cmd commits", 32'(en_total - en0), 32'd2);
    check("halt cmd drain", 32'(drain_total - dr0), 32'd1);
    check("halt cmd instr_cnt", instr_cnt, m_cnt);

    send(OP_RSVD, 0, 32'd0);
    check("op7 err", 32'(cmd_err), 32'd1);
    check("op7 halted", 32'(halted), 32'd1);
    @(negedge clk_cpu);
    check("op7 err pulse", 32'(cmd_err), 32'd0);

    for (int it = 0; it < 30; it++) begin
      act = $urandom_range(0, 4);
      s = $urandom_range(0, NBP - 1);
      case (act)
        0: send(OP_SET_BP, s, pc + 32'(4 * $urandom_range(1, 16)) + 32'($urandom_range(0, 3)));
        1: send(OP_CLR_BP, s, 32'd0);
        2: begin
          n = $urandom_range(0, 8);
          exec_and_check("rand step", OP_STEP, n);
        end
        3: begin
          k = first_hit(pc, 256, slot);
          if (k == 0) send(OP_SET_BP, s, pc + 32'(4 * $urandom_range(1, 20)));
          exec_and_check("rand run", OP_RUN, 0);
        end
        default: begin
          send(OP_CLR_CNT, 0, 32'd0);
          check("rand clr_cnt", instr_cnt, m_cnt);
        end
      endcase
    end

    send(OP_STEP, 0, 32'd20);
    repeat (3) @(negedge clk_cpu);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("reset in step");
    for (int i = 0; i < NBP; i++) m_en[i] = 1'b0;
    m_cnt = '0; m_cause = 2'd0; m_bpidx = '0;
    @(negedge clk_cpu);
    rstn = 1'b1;
    @(negedge clk_cpu);
    exec_and_check("post reset step", OP_STEP, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_exec_ctrl.md
# cpu_exec_ctrl

Execution controller for the single-cycle RISC-V core and its serial debug unit. It owns the core's commit enable (`cpu_en`) and the `debug` select that hands IM/DM/RF to the debug port. It sequences the core through the halt, run, N-step and breakpoint-stop states. It also inserts a one-cycle drain so that the core's registered writeback and store complete before the debug unit takes the memories.

## Interface
Parameters:
- NBP, 4, number of PC breakpoint slots (1..8)
- CNT_W, 16, width of the step counter

Ports:
- clk_cpu  in  1  core clock; all state updates on posedge
- rstn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command strobe from the debug unit
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  command opcode: 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved
- cmd_idx  in  $clog2(NBP)  breakpoint slot for SET_BP/CLR_BP
- cmd_data  in  32  RUN: ignored; STEP: count in [CNT_W-1:0]; SET_BP: breakpoint address
- cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the current state
- npc  in  32  the core's next-PC (combinational from the core)
- cpu_en  out  1  core commits the current instruction (PC update, RF/DM write) this cycle
- debug  out  1  1 = debug unit owns IM/DM/RF address ports
- halted  out  1  state == HALT
- halt_cause  out  2  0 reset, 1 HALT cmd, 2 step done, 3 breakpoint
- bp_idx  out  $clog2(NBP)  slot index of the last breakpoint hit
- instr_cnt  out  32  retired-instruction counter

## Operation
- States: HALT, RUN, STEP, DRAIN. All outputs are registered and decoded from the state.
- Reset: state HALT; cpu_en=0, debug=1, halted=1, cmd_ready=1, cmd_err=0, halt_cause=0, bp_idx=0, instr_cnt=0, all breakpoint slots disabled, step counter=0.
- HALT: cpu_en=0, debug=1, cmd_ready=1.
  - RUN moves to RUN.
  - STEP loads cnt = (cmd_data[CNT_W-1:0]==0) ? 1 : cmd_data[CNT_W-1:0] and moves to STEP.
  - SET_BP writes slot cmd_idx with address {cmd_data[31:2],2'b00} and sets its enable bit.
  - CLR_BP clears the enable bit of slot cmd_idx.
  - CLR_CNT zeroes instr_cnt.
  - HALT and NOP are accepted and have no effect.
  - Op 7 pulses cmd_err.
- RUN: cpu_en=1, debug=0, cmd_ready=1.
  - HALT moves to DRAIN with cause 1.
  - SET_BP, CLR_BP and CLR_CNT are allowed.
  - RUN and STEP pulse cmd_err and are otherwise ignored.
- STEP: cpu_en=1, debug=0, cmd_ready=0. Each cycle cnt decrements. When cnt==1, move to DRAIN with cause 2.
- Breakpoint check, in RUN and STEP:
  - Each cycle, compare npc[31:2] against every enabled slot.
  - On any match, move to DRAIN with cause 3 and bp_idx set to the lowest matching slot.
  - The instruction at the current PC commits; the breakpoint instruction itself does not execute.
  - Because the check uses npc, a RUN issued while PC already sits on a breakpoint executes that instruction.
- Priority when events coincide in one cycle: breakpoint (3) > HALT cmd (1) > step done (2). Only one cause is recorded.
- DRAIN: cpu_en=0, debug=0, cmd_ready=0 for exactly one cycle, then HALT.
- instr_cnt increments (wrapping at 2^32) on every cycle with cpu_en=1. CLR_CNT in the same cycle takes priority.
- Reset asserted mid-RUN/STEP returns immediately to the reset values. In-flight commit is not guaranteed.

## Timing
- Command accepted at edge k: the new state and outputs are visible after edge k. RUN issued at edge k gives cpu_en=1 from k to k+1.
- STEP N: cpu_en is high for exactly N cycles, followed by 1 DRAIN cycle; debug=1 on cycle N+2 after accept.
- Breakpoint match in cycle c: cpu_en=1 in c, 0 in c+1 (DRAIN), debug=1 from c+2.
- HALT cmd accepted in RUN cycle c: identical timing to a breakpoint match in cycle c.
- cmd_err pulses in the cycle after acceptance.
- SET_BP/CLR_BP take effect for the comparison in the cycle after acceptance.

## Structure
- Shared package `cpu_dbg_pkg`: cmd_op encodings, state enum, halt_cause encodings, and the default reset PC 32'h0000_3000 (used by the bench).
- Sub-module `bp_match_bank`: NBP address registers plus enable bits, the parallel comparator, and a lowest-index priority encoder producing `hit` and `idx`.

## Test plan
- Reset then idle 10 cycles -> halted=1, debug=1, cpu_en=0, halt_cause=0, instr_cnt=0.
- STEP cmd_data=3 -> cpu_en high exactly 3 cycles, then 1 DRAIN cycle; halt_cause=2, instr_cnt=3. Then STEP cmd_data=0 -> 1 instruction, instr_cnt=4.
- SET_BP idx1 addr 0x3010, RUN from 0x3000 with sequential npc -> cpu_en high 4 cycles (npc 0x3004..0x3010); halt_cause=3, bp_idx=1. RUN again -> no immediate re-stop at 0x3010.
- Slots 0 and 2 both set to 0x3008 -> bp_idx=0. After CLR_BP idx0 and re-run from 0x3000 -> bp_idx=2.
- RUN, then HALT cmd in the same cycle npc hits an enabled breakpoint -> halt_cause=3, single DRAIN cycle.
- RUN then STEP while running -> cmd_err pulse, state stays RUN. Op 7 in HALT -> cmd_err pulse. rstn low during STEP -> all outputs at reset values.
